regfile_wb_port_arb: RTL and testbench

REGFILE_WB_PORT_ARB -- requirements
Module: regfile_wb_port_arb

---
 rtl/regfile_wb_port_arb_pkg.sv | 25 ++
 rtl/regfile_wb_starve_ctr.sv | 47 ++++
 rtl/struct.sv | 4 +
 rtl/regfile_wb_port_arb.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_port_arb.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_port_arb_pkg.sv
// rtl/regfile_wb_port_arb_pkg.sv - shared parameters for the writeback port arbiter
//
// Purpose: default sizing for the writeback arbiter and its starvation counters.
// Contents: RF_ADDR_W (register address width taken from struct.sv), WB_NREQ,
// WB_NPORT, WB_STARVE, WB_SRC_W (requester index width), ctr_width().

// Same guarded value as struct.sv so the package compiles regardless of file order.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 6
`endif

package regfile_wb_port_arb_pkg;

  localparam int RF_ADDR_W  = `REG_ADDR_WIDTH;
  localparam int WB_NREQ    = 12;
  localparam int WB_NPORT   = 10;
  localparam int WB_STARVE  = 8;
  localparam int WB_SRC_W   = 4;

  // Bits needed to hold a wait count in 0..starve.
  function automatic int ctr_width(input int starve);
    return $clog2(starve + 1);
  endfunction

endpackage

// File: rtl/regfile_wb_starve_ctr.sv
// rtl/regfile_wb_starve_ctr.sv - per-requester saturating wait counter
//
// Purpose: counts cycles a requester is left waiting, saturating at STARVE.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   valid         requester holds a pending write
//   grant         requester was granted this cycle
//   starved       current count equals STARVE
//   starved_next  count after this edge will equal STARVE
module regfile_wb_starve_ctr
  import regfile_wb_port_arb_pkg::*;
#(
  parameter int STARVE = WB_STARVE,
  parameter int CW     = ctr_width(WB_STARVE)
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic grant,
  output logic starved,
  output logic starved_next
);

  localparam logic [CW-1:0] SAT = CW'(STARVE);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (valid && !grant) begin
      cnt_next = (cnt == SAT) ? cnt : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign starved      = (cnt == SAT);
  assign starved_next = (cnt_next == SAT);

endmodule

// File: rtl/struct.sv
// rtl/struct.sv - shared register-file geometry macros
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 6
`endif

// File: rtl/regfile_wb_port_arb.sv
// rtl/regfile_wb_port_arb.sv - writeback requester to regfile write-port arbiter
//
// Purpose: each cycle, grants pending writeback requesters onto available
// regfile write ports (starved requesters first, then round-robin), never
// granting two writes to the same register in one cycle, and registers the
// resulting per-port write address/enable/source.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    [NREQ]              requester k has a write pending
//   req_addr     [NREQ*ADDR_WIDTH]   destination register of requester k
//   req_grant    [NREQ]              combinational grant (transfer when valid & grant)
//   port_en      [NPORT]             write port p available this cycle
//   wr_addr_reg  [NPORT*ADDR_WIDTH]  registered write address per port
//   wr_wen_reg   [NPORT]             registered write enable per port
//   wr_src_reg   [NPORT*4]           registered granted requester index per port
//   starve_flag                      registered: some wait counter is at STARVE
module regfile_wb_port_arb
  import regfile_wb_port_arb_pkg::*;
#(
  parameter int NREQ       = WB_NREQ,
  parameter int NPORT      = WB_NPORT,
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int STARVE     = WB_STARVE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0]  req_addr,
  output logic [NREQ-1:0]             req_grant,
  input  logic [NPORT-1:0]            port_en,
  output logic [NPORT*ADDR_WIDTH-1:0] wr_addr_reg,
  output logic [NPORT-1:0]            wr_wen_reg,
  output logic [NPORT*WB_SRC_W-1:0]   wr_src_reg,
  output logic                        starve_flag
);

  localparam int CW = ctr_width(STARVE);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]             starved;
  logic [NREQ-1:0]             starved_next;
  logic [NREQ-1:0]             grant;
  logic [PW-1:0]               rr_ptr;
  logic [PW-1:0]               rr_next;
  logic [NPORT-1:0]            used;
  logic [NPORT-1:0]            asg_wen;
  logic [NPORT*ADDR_WIDTH-1:0] asg_addr;
  logic [NPORT*WB_SRC_W-1:0]   asg_src;

  // Two scan passes: pass 0 visits starved requesters in ascending index,
  // pass 1 visits the rest circularly from rr_ptr. Each successful grant
  // takes the lowest-indexed enabled port not yet used, so the i-th grant
  // lands on the i-th enabled port.
  always_comb begin
    int  k;
    logic eligible;
    logic conflict;
    logic placed;
    k        = 0;
    eligible = 1'b0;
    conflict = 1'b0;
    placed   = 1'b0;
    grant    = '0;
    used     = '0;
    asg_wen  = '0;
    asg_addr = '0;
    asg_src  = '0;
    rr_next  = rr_ptr;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < NREQ; j++) begin
        k        = (pass == 0) ? j : (int'(rr_ptr) + j) % NREQ;
        eligible = (pass == 0) ? starved[k] : !starved[k];
        conflict = 1'b0;
        placed   = 1'b0;
        if (req_valid[k] && eligible) begin
          // Same destination already granted this cycle: this one waits.
          for (int m = 0; m < NREQ; m++) begin
            if (grant[m] && (req_addr[m*ADDR_WIDTH +: ADDR_WIDTH] ==
                             req_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
              conflict = 1'b1;
            end
          end
          if (!conflict) begin
            for (int p = 0; p < NPORT; p++) begin
              if (!placed && port_en[p] && !used[p]) begin
                placed     = 1'b1;
                used[p]    = 1'b1;
                asg_wen[p] = 1'b1;
                asg_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                asg_src[p*WB_SRC_W +: WB_SRC_W]      = WB_SRC_W'(k);
              end
            end
          end
          if (placed) begin
            grant[k] = 1'b1;
            if (pass == 1) begin
              rr_next = (k == NREQ - 1) ? '0 : PW'(k + 1);
            end
          end
        end
      end
    end
    if (rst) begin
      grant = '0;
    end
  end

  assign req_grant = grant;

  for (genvar g = 0; g < NREQ; g++) begin : g_ctr
    regfile_wb_starve_ctr #(
      .STARVE (STARVE),
      .CW     (CW)
    ) u_ctr (
      .clk          (clk),
      .rst          (rst),
      .valid        (req_valid[g]),
      .grant        (grant[g]),
      .starved      (starved[g]),
      .starved_next (starved_next[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_wen_reg  <= '0;
      wr_addr_reg <= '0;
      wr_src_reg  <= '0;
      starve_flag <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      wr_wen_reg  <= asg_wen;
      wr_addr_reg <= asg_addr;
      wr_src_reg  <= asg_src;
      starve_flag <= |starved_next;
      rr_ptr      <= rr_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_port_arb.sv
// tb/tb_regfile_wb_port_arb.sv - directed self-checking bench for regfile_wb_port_arb
module tb_regfile_wb_port_arb;
  import regfile_wb_port_arb_pkg::*;

  localparam int NREQ  = 12;
  localparam int NPORT = 10;
  localparam int AW    = RF_ADDR_W;
  localparam int SW    = WB_SRC_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ-1:0]       req_grant;
  logic [NPORT-1:0]      port_en = '0;
  logic [NPORT*AW-1:0]   wr_addr_reg;
  logic [NPORT-1:0]      wr_wen_reg;
  logic [NPORT*SW-1:0]   wr_src_reg;
  logic                  starve_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_port_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_grant   (req_grant),
    .port_en     (port_en),
    .wr_addr_reg (wr_addr_reg),
    .wr_wen_reg  (wr_wen_reg),
    .wr_src_reg  (wr_src_reg),
    .starve_flag (starve_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester k targets register k+1.
  task automatic set_distinct_addrs();
    for (int k = 0; k < NREQ; k++) req_addr[k*AW +: AW] = AW'(k + 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    port_en = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_distinct_addrs();
    req_valid = 12'hFFF;
    port_en = 10'h3FF;
    #1;
    checks++;
    if (req_grant !== 12'h000) begin errors++; $display("FAIL reset_grant: got %h want 000", req_grant); end
    tick();
    tick();
    checks++;
    if (wr_wen_reg !== 10'h000) begin errors++; $display("FAIL reset_wen: got %h want 000", wr_wen_reg); end
    checks++;
    if (starve_flag !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b want 0", starve_flag); end
    checks++;
    if (dut.rr_ptr !== 4'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
    rst = 1'b0;
    req_valid = '0;
    port_en = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    set_distinct_addrs();
    req_valid = 12'hFFF;
    port_en = 10'h3FF;
    #1;
    checks++;
    if (req_grant !== 12'h3FF) begin errors++; $display("FAIL rr1_grant: got %h want 3ff", req_grant); end
    tick();
    checks++;
    if (wr_wen_reg !== 10'h3FF) begin errors++; $display("FAIL rr1_wen: got %h want 3ff", wr_wen_reg); end
    checks++;
    if (wr_src_reg[9*SW +: SW] !== 4'd9) begin errors++; $display("FAIL rr1_src9: got %0d want 9", wr_src_reg[9*SW +: SW]); end
    checks++;
    if (wr_addr_reg[3*AW +: AW] !== AW'(4)) begin errors++; $display("FAIL rr1_addr3: got %0d want 4", wr_addr_reg[3*AW +: AW]); end
    checks++;
    if (dut.rr_ptr !== 4'd10) begin errors++; $display("FAIL rr1_ptr: got %0d want 10", dut.rr_ptr); end
    #1;
    checks++;
    if (req_grant !== 12'hCFF) begin errors++; $display("FAIL rr2_grant: got %h want cff", req_grant); end
    tick();
    checks++;
    if (wr_src_reg[0 +: SW] !== 4'd10) begin errors++; $display("FAIL rr2_src0: got %0d want 10", wr_src_reg[0 +: SW]); end
    checks++;
    if (wr_src_reg[1*SW +: SW] !== 4'd11) begin errors++; $display("FAIL rr2_src1: got %0d want 11", wr_src_reg[1*SW +: SW]); end
    checks++;
    if (wr_src_reg[2*SW +: SW] !== 4'd0) begin errors++; $display("FAIL rr2_src2: got %0d want 0", wr_src_reg[2*SW +: SW]); end
    checks++;
    if (dut.rr_ptr !== 4'd8) begin errors++; $display("FAIL rr2_ptr: got %0d want 8", dut.rr_ptr); end
    #1;
    checks++;
    if (req_grant !== 12'hF3F) begin errors++; $display("FAIL rr3_grant: got %h want f3f", req_grant); end
  endtask

  task automatic test_addr_conflict();
    do_reset();
    set_distinct_addrs();
    req_addr[3*AW +: AW] = AW'(7);
    req_addr[5*AW +: AW] = AW'(7);
    req_valid = 12'h028;
    port_en = 10'h3FF;
    #1;
    checks++;
    if (req_grant !== 12'h008) begin errors++; $display("FAIL conflict1_grant: got %h want 008", req_grant); end
    tick();
    checks++;
    if (wr_wen_reg !== 10'h001) begin errors++; $display("FAIL conflict1_wen: got %h want 001", wr_wen_reg); end
    checks++;
    if (wr_src_reg[0 +: SW] !== 4'd3) begin errors++; $display("FAIL conflict1_src0: got %0d want 3", wr_src_reg[0 +: SW]); end
    checks++;
    if (wr_addr_reg[0 +: AW] !== AW'(7)) begin errors++; $display("FAIL conflict1_addr0: got %0d want 7", wr_addr_reg[0 +: AW]); end
    checks++;
    if (req_grant !== 12'h020) begin errors++; $display("FAIL conflict2_grant: got %h want 020", req_grant); end
    tick();
    checks++;
    if (wr_src_reg[0 +: SW] !== 4'd5) begin errors++; $display("FAIL conflict2_src0: got %0d want 5", wr_src_reg[0 +: SW]); end
    req_valid = '0;
  endtask

  task automatic test_port_binding();
    do_reset();
    set_distinct_addrs();
    req_valid = 12'h007;
    port_en = 10'h204;
    #1;
    checks++;
    if (req_grant !== 12'h003) begin errors++; $display("FAIL bind_grant: got %h want 003", req_grant); end
    tick();
    checks++;
    if (wr_wen_reg !== 10'h204) begin errors++; $display("FAIL bind_wen: got %h want 204", wr_wen_reg); end
    checks++;
    if (wr_src_reg[2*SW +: SW] !== 4'd0) begin errors++; $display("FAIL bind_src2: got %0d want 0", wr_src_reg[2*SW +: SW]); end
    checks++;
    if (wr_src_reg[9*SW +: SW] !== 4'd1) begin errors++; $display("FAIL bind_src9: got %0d want 1", wr_src_reg[9*SW +: SW]); end
    checks++;
    if (wr_addr_reg[9*AW +: AW] !== AW'(2)) begin errors++; $display("FAIL bind_addr9: got %0d want 2", wr_addr_reg[9*AW +: AW]); end
    checks++;
    if (wr_addr_reg[0 +: AW] !== AW'(0)) begin errors++; $display("FAIL bind_addr0_idle: got %0d want 0", wr_addr_reg[0 +: AW]); end
    checks++;
    if (dut.g_ctr[2].u_ctr.cnt !== 4'd1) begin errors++; $display("FAIL bind_cnt2: got %0d want 1", dut.g_ctr[2].u_ctr.cnt); end
    req_valid = '0;
  endtask

  task automatic test_starvation();
    do_reset();
    set_distinct_addrs();
    req_valid = 12'h010;
    port_en = 10'h000;
    #1;
    checks++;
    if (req_grant !== 12'h000) begin errors++; $display("FAIL starve_nogrant: got %h want 000", req_grant); end
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if (starve_flag !== 1'b0) begin errors++; $display("FAIL starve_flag7: got %b want 0", starve_flag); end
    tick();
    checks++;
    if (dut.g_ctr[4].u_ctr.cnt !== 4'd8) begin errors++; $display("FAIL starve_cnt4: got %0d want 8", dut.g_ctr[4].u_ctr.cnt); end
    checks++;
    if (starve_flag !== 1'b1) begin errors++; $display("FAIL starve_flag8: got %b want 1", starve_flag); end
    tick();
    checks++;
    if (dut.g_ctr[4].u_ctr.cnt !== 4'd8) begin errors++; $display("FAIL starve_sat: got %0d want 8", dut.g_ctr[4].u_ctr.cnt); end
    req_valid = 12'hFFF;
    port_en = 10'h001;
    #1;
    checks++;
    if (req_grant !== 12'h010) begin errors++; $display("FAIL starve_grant: got %h want 010", req_grant); end
    tick();
    checks++;
    if (wr_src_reg[0 +: SW] !== 4'd4) begin errors++; $display("FAIL starve_src0: got %0d want 4", wr_src_reg[0 +: SW]); end
    checks++;
    if (dut.rr_ptr !== 4'd0) begin errors++; $display("FAIL starve_rr_ptr: got %0d want 0", dut.rr_ptr); end
    req_valid = '0;
    port_en = '0;
  endtask

  task automatic test_reset_active();
    do_reset();
    set_distinct_addrs();
    req_valid = 12'hFFF;
    port_en = 10'h3FF;
    tick();
    checks++;
    if (dut.g_ctr[10].u_ctr.cnt !== 4'd1) begin errors++; $display("FAIL rstact_cnt10_pre: got %0d want 1", dut.g_ctr[10].u_ctr.cnt); end
    rst = 1'b1;
    #1;
    checks++;
    if (req_grant !== 12'h000) begin errors++; $display("FAIL rstact_grant: got %h want 000", req_grant); end
    tick();
    checks++;
    if (wr_wen_reg !== 10'h000) begin errors++; $display("FAIL rstact_wen: got %h want 000", wr_wen_reg); end
    checks++;
    if (wr_src_reg !== '0) begin errors++; $display("FAIL rstact_src: got %h want 0", wr_src_reg); end
    checks++;
    if (dut.g_ctr[10].u_ctr.cnt !== 4'd0) begin errors++; $display("FAIL rstact_cnt10: got %0d want 0", dut.g_ctr[10].u_ctr.cnt); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_grant !== 12'h3FF) begin errors++; $display("FAIL rstact_regrant: got %h want 3ff", req_grant); end
    req_valid = '0;
    port_en = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_addr_conflict();
    test_port_binding();
    test_starvation();
    test_reset_active();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
